tlu_emulator: RTL

TLU_EMULATOR -- requirements
Module: tlu_emulator

---
 rtl/tlu_emulator.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlu_emulator.sv
// ---------------------------------------------------------------------------
// tlu_emulator
//   Emulates an EUDAQ-style Trigger Logic Unit towards a device under test.
//   A request pulse starts one trigger cycle in one of three modes:
//     simple         : fixed-width TRIGGER pulse, BUSY ignored
//     handshake      : TRIGGER until BUSY rises, done when BUSY falls
//     data handshake : as handshake, plus the trigger number is shifted out
//                      LSB first on TRIGGER, one bit per TLU_CLOCK rising edge
//   BUSY and TLU_CLOCK come from another clock domain and are synchronised.
//
// Ports
//   CLK, RST_B    : system clock (rising edge), async active-low reset
//   EN            : accept trigger requests
//   MODE[1:0]     : 0 simple, 1 handshake, 2/3 data handshake (sampled in IDLE)
//   TRIG_REQ      : single-cycle trigger request
//   BUSY          : asynchronous busy from the DUT
//   TLU_CLOCK     : asynchronous shift clock from the DUT
//   CLR_ERR       : clears TIMEOUT_ERR and MISSED_CNT
//   TRIGGER       : trigger / serial trigger-number line
//   READY         : high while idle
//   TRIG_CNT      : number of the next trigger to send
//   MISSED_CNT    : saturating count of dropped requests
//   TIMEOUT_ERR   : sticky handshake timeout flag
// ---------------------------------------------------------------------------
module tlu_emulator #(
  parameter int TRIG_BITS = 15,
  parameter int TRIG_LEN  = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic                 TRIG_REQ,
  input  logic                 BUSY,
  input  logic                 TLU_CLOCK,
  input  logic                 CLR_ERR,
  output logic                 TRIGGER,
  output logic                 READY,
  output logic [TRIG_BITS-1:0] TRIG_CNT,
  output logic [7:0]           MISSED_CNT,
  output logic                 TIMEOUT_ERR
);

  // The state counter doubles as the simple-mode pulse-length counter, so it
  // must be wide enough for whichever of the two limits is larger.
  localparam int TMO_MAX = (TIMEOUT > TRIG_LEN) ? TIMEOUT : TRIG_LEN;
  localparam int TW      = $clog2(TMO_MAX + 1);
  localparam int BW      = $clog2(TRIG_BITS + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 trigger_q, trigger_d;
  logic [TRIG_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [1:0]           mode_q, mode_d;
  logic [TRIG_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]           missed_q, missed_d;
  logic                 err_q, err_d;

  logic                 busy_meta_q, busy_s_q;
  logic                 clk_meta_q, clk_s_q, clk_prev_q;

  logic [TW-1:0]        tmo_inc;
  logic                 tmo_hit;
  logic                 clk_edge;
  logic                 accept;
  logic                 err_set;

  // Two-flop synchronisers for the DUT-side signals plus a history flop on the
  // shift clock; a TLU_CLOCK edge is acted on three CLK cycles after the pin.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      clk_meta_q  <= 1'b0;
      clk_s_q     <= 1'b0;
      clk_prev_q  <= 1'b0;
    end else begin
      busy_meta_q <= BUSY;
      busy_s_q    <= busy_meta_q;
      clk_meta_q  <= TLU_CLOCK;
      clk_s_q     <= clk_meta_q;
      clk_prev_q  <= clk_s_q;
    end
  end

  assign clk_edge = clk_s_q & ~clk_prev_q;
  assign tmo_inc  = tmo_q + 1'b1;
  assign tmo_hit  = (tmo_inc == TW'(TIMEOUT));

  // Trigger sequencer. TRIGGER is registered, so every value chosen here
  // appears on the pin one cycle later. The timeout counter is zeroed on
  // every state change and counts only in the states that wait on the DUT.
  always_comb begin
    state_d   = state_q;
    trigger_d = trigger_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    tmo_d     = tmo_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        trigger_d = 1'b0;
        if (TRIG_REQ && EN) begin
          accept   = 1'b1;
          shift_d  = cnt_q;
          mode_d   = MODE;
          bitcnt_d = '0;
          tmo_d    = '0;
          state_d  = S_TRIG;
        end
      end

      S_TRIG: begin
        if (mode_q == 2'd0) begin
          // Simple mode: the pulse is high for TRIG_LEN cycles, BUSY unused.
          if (tmo_q == TW'(TRIG_LEN)) begin
            trigger_d = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            tmo_d     = '0;
            state_d   = S_IDLE;
          end else begin
            trigger_d = 1'b1;
            tmo_d     = tmo_inc;
          end
        end else if (busy_s_q) begin
          trigger_d = 1'b0;
          tmo_d     = '0;
          state_d   = mode_q[1] ? S_SHIFT : S_WAIT_IDLE;
        end else if (tmo_hit) begin
          // BUSY never arrived, so this trigger does not count.
          trigger_d = 1'b0;
          err_set   = 1'b1;
          tmo_d     = '0;
          state_d   = S_IDLE;
        end else begin
          trigger_d = 1'b1;
          tmo_d     = tmo_inc;
        end
      end

      S_SHIFT: begin
        if (!busy_s_q) begin
          // The DUT may end the handshake before every bit has been shifted.
          trigger_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          tmo_d     = '0;
          state_d   = S_IDLE;
        end else if (tmo_hit) begin
          trigger_d = 1'b0;
          err_set   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          tmo_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (clk_edge) begin
            if (bitcnt_q < BW'(TRIG_BITS)) begin
              trigger_d = shift_q[0];
              shift_d   = shift_q >> 1;
              bitcnt_d  = bitcnt_q + 1'b1;
            end else begin
              // One extra edge after the last bit releases the line.
              trigger_d = 1'b0;
              tmo_d     = '0;
              state_d   = S_WAIT_IDLE;
            end
          end
        end
      end

      S_WAIT_IDLE: begin
        trigger_d = 1'b0;
        if (!busy_s_q) begin
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      // S_WAIT_BUSY is reserved (TRIG itself waits for BUSY); it and any
      // illegal encoding fall back to idle.
      S_WAIT_BUSY: begin
        trigger_d = 1'b0;
        tmo_d     = '0;
        state_d   = S_IDLE;
      end

      default: begin
        trigger_d = 1'b0;
        tmo_d     = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Error bookkeeping. A clear request beats a simultaneous timeout or a
  // simultaneous dropped request.
  always_comb begin
    err_d    = err_q;
    missed_d = missed_q;
    if (CLR_ERR) begin
      err_d    = 1'b0;
      missed_d = '0;
    end else begin
      if (err_set) begin
        err_d = 1'b1;
      end
      if (TRIG_REQ && !accept && (missed_q != 8'hFF)) begin
        missed_d = missed_q + 1'b1;
      end
    end
  end

  // State and datapath registers; reset abandons any trigger in flight.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q   <= S_IDLE;
      trigger_q <= 1'b0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      tmo_q     <= '0;
      mode_q    <= 2'd0;
      cnt_q     <= '0;
      missed_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      trigger_q <= trigger_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      tmo_q     <= tmo_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      missed_q  <= missed_d;
      err_q     <= err_d;
    end
  end

  assign TRIGGER     = trigger_q;
  assign READY       = (state_q == S_IDLE);
  assign TRIG_CNT    = cnt_q;
  assign MISSED_CNT  = missed_q;
  assign TIMEOUT_ERR = err_q;

endmodule
